pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Owns the program counter register and the multi-cycle phase sequencer of the 12-bit processor core.
- Drives `phase` and `pc_plus1` (the `from_adder` value) into the downstream next-PC select stage.
- Consumes that stage's `next_pc` / `pc_enable` to update the PC.
- Adds run/halt control, stall hold and a retired-instruction counter.

Parameters:
- RESET_PC, 12'h000, PC value loaded on reset.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
- run  in  1  start/resume request (level, sampled each cycle).
- halt_req  in  1  request to stop after the current instruction completes.
- stall  in  1  hold the current phase (memory/regfile not ready).
- next_pc  in  12  candidate PC from the next-PC select stage.
- pc_enable  in  1  next-PC select stage requests a PC load.
- phase  out  3  current phase: IF=3'b000, ID=3'b001, EX=3'b010, MEM=3'b011, WB=3'b100.
- pc  out  12  current program counter.
- pc_plus1  out  12  pc + 1, modulo 2^12 (combinational from pc).
- running  out  1  high in RUN state.
- halted  out  1  high in HALTED state.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (rst_n==0 at a clock edge):
  - state=IDLE, phase=IF, pc=RESET_PC, retired=0, running=0, halted=0.
  - Reset overrides every other input in the same cycle, including mid-phase and mid-stall.
- State machine, one of IDLE / RUN / HALTED:
  - IDLE -> RUN when run==1; entry phase is IF.
  - RUN -> HALTED at the WB-exit edge (advance in WB) if a halt is pending.
  - HALTED -> RUN when run==1; resumes at IF with pc unchanged.
  - run is ignored while in RUN.
- Halt pending flag:
  - Set when halt_req==1 in RUN.
  - Cleared on entering HALTED or on reset.
  - halt_req asserted during WB of the same cycle counts, so the halt occurs at that WB exit.
- advance = (state==RUN) && !stall.
- Phase sequencing:
  - On advance: IF->ID->EX->MEM->WB->IF.
  - Without advance: phase holds.
  - In IDLE and HALTED, phase is forced to IF.
  - phase never takes the values 3'b101..3'b111; if one is ever seen, the next edge returns it to IF.
- PC update:
  - pc <= next_pc only when advance && phase==EX && pc_enable.
  - A stall in EX must not load, so pc does not creep while the downstream select repeatedly offers pc_plus1.
  - pc_enable outside EX is ignored.
- pc_plus1: combinational; pc=12'hFFF gives 12'h000. Jump targets are taken verbatim.
- retired:
  - Increments by 1 on every WB-exit edge (advance && phase==WB), including the instruction on which a halt takes effect.
  - Wraps modulo 2^CNT_W.
- Outputs:
  - phase, pc, retired, running and halted are registered.
  - running and halted are decoded from state and change on the same edge as the state.
- Latency:
  - One instruction takes 5 cycles with no stalls.
  - The first IF is the cycle after run is sampled.

Decomposition:
- Shared package (cpu_pkg):
  - Phase encoding constants PH_IF, PH_ID, PH_EX, PH_MEM, PH_WB, also used by the next-PC select stage and decoder.
  - State constants ST_IDLE, ST_RUN, ST_HALTED.
  - PC width constant PC_W=12.
- One natural sub-module: phase_counter, containing the 3-bit phase register plus the advance/force-IF logic.
- pc_sequencer instantiates phase_counter and holds the PC, control FSM and counter.

Test Plan:
- Reset then run pulse, no stall, pc_enable=1 in EX with next_pc=pc_plus1 -> phase cycles 0,1,2,3,4,0; pc goes 000->001 at EX exit; retired=1 after 5 cycles.
- stall=1 for 3 cycles during EX, pc_enable=1, next_pc=pc_plus1 -> phase stays 010 and pc unchanged for all 3 cycles; pc increments exactly once on release.
- Jump: in EX, next_pc=12'h3A5, pc_enable=1 -> pc=12'h3A5 in the MEM cycle; pc_plus1=12'h3A6.
- pc=12'hFFF -> pc_plus1=12'h000; EX load of pc_plus1 gives pc=000.
- halt_req pulse during ID -> instruction completes; halted=1 after WB exit; phase=IF and retired +1; then run=1 -> resumes at IF with the same pc.
- rst_n=0 during MEM with stall=1 -> next edge: phase=IF, pc=RESET_PC, retired=0, state IDLE.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 12-bit core: phase encoding, control states, PC width.
package cpu_pkg;

  localparam int PC_W = 12;

  localparam logic [2:0] PH_IF  = 3'b000;
  localparam logic [2:0] PH_ID  = 3'b001;
  localparam logic [2:0] PH_EX  = 3'b010;
  localparam logic [2:0] PH_MEM = 3'b011;
  localparam logic [2:0] PH_WB  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  // Successor in the IF..WB ring; any unused code falls back to IF.
  function automatic logic [2:0] phase_succ(input logic [2:0] ph);
    case (ph)
      PH_IF:   phase_succ = PH_ID;
      PH_ID:   phase_succ = PH_EX;
      PH_EX:   phase_succ = PH_MEM;
      PH_MEM:  phase_succ = PH_WB;
      default: phase_succ = PH_IF;
    endcase
  endfunction

endpackage

// File: rtl/pc_sequencer_phase_counter.sv
// 3-bit phase register: steps the IF..WB ring on advance, pinned to IF when not running.
module phase_counter
  import cpu_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_advance,
  input  logic       i_force_if,
  output logic [2:0] o_phase
);

  logic [2:0] r_phase;
  logic [2:0] w_phase_nxt;

  always_comb begin
    w_phase_nxt = r_phase;
    if (r_phase > PH_WB)   w_phase_nxt = PH_IF;
    else if (i_force_if)   w_phase_nxt = PH_IF;
    else if (i_advance)    w_phase_nxt = phase_succ(r_phase);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_phase <= PH_IF;
    else          r_phase <= w_phase_nxt;
  end

  assign o_phase = r_phase;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter, run/halt control FSM and retired-instruction counter of the core.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 12'h000,
  parameter int              CNT_W    = 16
)(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_run,
  input  logic             i_halt_req,
  input  logic             i_stall,
  input  logic [PC_W-1:0]  i_next_pc,
  input  logic             i_pc_enable,
  output logic [2:0]       o_phase,
  output logic [PC_W-1:0]  o_pc,
  output logic [PC_W-1:0]  o_pc_plus1,
  output logic             o_running,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_retired
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_halt_pend;
  logic [PC_W-1:0]  r_pc;
  logic [CNT_W-1:0] r_retired;

  logic       w_advance;
  logic       w_wb_exit;
  logic       w_pc_load;
  logic       w_halt_eff;
  logic       w_enter_halt;
  logic [2:0] w_phase;

  assign w_advance    = (r_state == ST_RUN) && !i_stall;
  assign w_wb_exit    = w_advance && (w_phase == PH_WB);
  assign w_pc_load    = w_advance && (w_phase == PH_EX) && i_pc_enable;
  // A request arriving in the WB cycle itself still stops at this WB exit.
  assign w_halt_eff   = r_halt_pend || ((r_state == ST_RUN) && i_halt_req);
  assign w_enter_halt = (r_state == ST_RUN) && w_wb_exit && w_halt_eff;

  phase_counter u_phase (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_advance  (w_advance),
    .i_force_if (r_state != ST_RUN),
    .o_phase    (w_phase)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (i_run)        w_state_nxt = ST_RUN;
      ST_RUN:    if (w_enter_halt) w_state_nxt = ST_HALTED;
      ST_HALTED: if (i_run)        w_state_nxt = ST_RUN;
      default:                     w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_running = (r_state == ST_RUN);
    o_halted  = (r_state == ST_HALTED);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                               r_halt_pend <= 1'b0;
    else if (w_enter_halt)                      r_halt_pend <= 1'b0;
    else if ((r_state == ST_RUN) && i_halt_req) r_halt_pend <= 1'b1;
  end

  // Loading only on advance keeps pc from creeping while EX is stalled.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)       r_pc <= RESET_PC;
    else if (w_pc_load) r_pc <= i_next_pc;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)       r_retired <= '0;
    else if (w_wb_exit) r_retired <= r_retired + CNT_W'(1);
  end

  assign o_phase    = w_phase;
  assign o_pc       = r_pc;
  assign o_pc_plus1 = r_pc + PC_W'(1);
  assign o_retired  = r_retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer plus a retired-counter wrap sequence.
module tb_pc_sequencer;
  localparam int CW = 3;

  logic          clk, rst_n, run, halt_req, stall, pc_enable;
  logic [11:0]   next_pc;
  logic [2:0]    phase;
  logic [11:0]   pc, pc_plus1;
  logic          running, halted;
  logic [CW-1:0] retired;

  int total = 0;
  int passed = 0;

  pc_sequencer #(.RESET_PC(12'h000), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_halt_req(halt_req),
    .i_stall(stall), .i_next_pc(next_pc), .i_pc_enable(pc_enable),
    .o_phase(phase), .o_pc(pc), .o_pc_plus1(pc_plus1),
    .o_running(running), .o_halted(halted), .o_retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst_n, run, halt, stall, en;
    logic [11:0]   npc;
    logic [2:0]    ph;
    logic [11:0]   pc;
    logic          ro, ho;
    logic [CW-1:0] ret;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(input logic r, input logic rn, input logic h, input logic s,
                             input logic e, input logic [11:0] np, input logic [2:0] ph,
                             input logic [11:0] p, input logic ro, input logic ho,
                             input logic [CW-1:0] rt);
    vec_t x;
    x.rst_n = r; x.run = rn; x.halt = h; x.stall = s; x.en = e; x.npc = np;
    x.ph = ph; x.pc = p; x.ro = ro; x.ho = ho; x.ret = rt;
    return x;
  endfunction

  task automatic check(input string name, input logic [2:0] eph, input logic [11:0] epc,
                       input logic ero, input logic eho, input logic [CW-1:0] eret);
    logic [11:0] ep1;
    ep1 = epc + 12'd1;
    total++;
    if (phase === eph && pc === epc && pc_plus1 === ep1 && running === ero &&
        halted === eho && retired === eret)
      passed++;
    else
      $display("FAIL %s: got ph=%0h pc=%h p1=%h run=%b hlt=%b ret=%0d, want ph=%0h pc=%h p1=%h run=%b hlt=%b ret=%0d",
               name, phase, pc, pc_plus1, running, halted, retired,
               eph, epc, ep1, ero, eho, eret);
  endtask

  task automatic drive(input logic r, input logic rn, input logic h, input logic s,
                       input logic e, input logic [11:0] np);
    rst_n = r; run = rn; halt_req = h; stall = s; pc_enable = e; next_pc = np;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 0; run = 0; halt_req = 0; stall = 0; pc_enable = 0; next_pc = '0;
    //           rst run hlt stl en  npc     ph  pc      ro ho ret
    vt.push_back(v(0, 0, 0, 0, 0, 12'h000, 0, 12'h000, 0, 0, 0)); // reset
    vt.push_back(v(1, 0, 0, 0, 0, 12'h000, 0, 12'h000, 0, 0, 0)); // idle
    vt.push_back(v(1, 1, 0, 0, 0, 12'h000, 0, 12'h000, 1, 0, 0)); // run sampled
    vt.push_back(v(1, 0, 0, 0, 0, 12'h000, 1, 12'h000, 1, 0, 0));
    vt.push_back(v(1, 0, 0, 0, 0, 12'h000, 2, 12'h000, 1, 0, 0));
    vt.push_back(v(1, 0, 0, 0, 1, 12'h001, 3, 12'h001, 1, 0, 0)); // EX load
    vt.push_back(v(1, 0, 0, 0, 0, 12'h000, 4, 12'h001, 1, 0, 0));
    vt.push_back(v(1, 0, 0, 0, 0, 12'h000, 0, 12'h001, 1, 0, 1)); // retire 1
    vt.push_back(v(1, 0, 0, 0, 0, 12'h000, 1, 12'h001, 1, 0, 1));
    vt.push_back(v(1, 0, 0, 0, 0, 12'h000, 2, 12'h001, 1, 0, 1));
    vt.push_back(v(1, 0, 0, 1, 1, 12'h002, 2, 12'h001, 1, 0, 1)); // stall in EX x3
    vt.push_back(v(1, 0, 0, 1, 1, 12'h002, 2, 12'h001, 1, 0, 1));
    vt.push_back(v(1, 0, 0, 1, 1, 12'h002, 2, 12'h001, 1, 0, 1));
    vt.push_back(v(1, 0, 0, 0, 1, 12'h002, 3, 12'h002, 1, 0, 1)); // release: one load
    vt.push_back(v(1, 0, 0, 0, 1, 12'h0AB, 4, 12'h002, 1, 0, 1)); // en in MEM ignored
    vt.push_back(v(1, 0, 0, 0, 0, 12'h000, 0, 12'h002, 1, 0, 2));
    vt.push_back(v(1, 0, 0, 0, 0, 12'h000, 1, 12'h002, 1, 0, 2));
    vt.push_back(v(1, 0, 0, 0, 0, 12'h000, 2, 12'h002, 1, 0, 2));
    vt.push_back(v(1, 0, 0, 0, 1, 12'h3A5, 3, 12'h3A5, 1, 0, 2)); // jump
    vt.push_back(v(1, 0, 0, 0, 0, 12'h000, 4, 12'h3A5, 1, 0, 2));
    vt.push_back(v(1, 0, 0, 0, 0, 12'h000, 0, 12'h3A5, 1, 0, 3));
    vt.push_back(v(1, 0, 0, 0, 0, 12'h000, 1, 12'h3A5, 1, 0, 3));
    vt.push_back(v(1, 0, 0, 0, 0, 12'h000, 2, 12'h3A5, 1, 0, 3));
    vt.push_back(v(1, 0, 0, 0, 1, 12'hFFF, 3, 12'hFFF, 1, 0, 3)); // pc=FFF, p1=000
    vt.push_back(v(1, 0, 0, 0, 0, 12'h000, 4, 12'hFFF, 1, 0, 3));
    vt.push_back(v(1, 0, 0, 0, 0, 12'h000, 0, 12'hFFF, 1, 0, 4));
    vt.push_back(v(1, 0, 0, 0, 0, 12'h000, 1, 12'hFFF, 1, 0, 4));
    vt.push_back(v(1, 0, 0, 0, 0, 12'h000, 2, 12'hFFF, 1, 0, 4));
    vt.push_back(v(1, 0, 0, 0, 1, 12'h000, 3, 12'h000, 1, 0, 4)); // wrap load
    vt.push_back(v(1, 0, 0, 0, 0, 12'h000, 4, 12'h000, 1, 0, 4));
    vt.push_back(v(1, 0, 0, 0, 0, 12'h000, 0, 12'h000, 1, 0, 5));
    vt.push_back(v(1, 0, 0, 0, 0, 12'h000, 1, 12'h000, 1, 0, 5));
    vt.push_back(v(1, 0, 1, 0, 0, 12'h000, 2, 12'h000, 1, 0, 5)); // halt_req in ID
    vt.push_back(v(1, 0, 0, 0, 0, 12'h000, 3, 12'h000, 1, 0, 5));
    vt.push_back(v(1, 0, 0, 0, 0, 12'h000, 4, 12'h000, 1, 0, 5));
    vt.push_back(v(1, 0, 0, 0, 0, 12'h000, 0, 12'h000, 0, 1, 6)); // halted at WB exit
    vt.push_back(v(1, 0, 0, 0, 0, 12'h000, 0, 12'h000, 0, 1, 6));
    vt.push_back(v(1, 1, 0, 0, 0, 12'h000, 0, 12'h000, 1, 0, 6)); // resume
    vt.push_back(v(1, 1, 0, 0, 0, 12'h000, 1, 12'h000, 1, 0, 6)); // run ignored in RUN
    vt.push_back(v(1, 0, 0, 0, 0, 12'h000, 2, 12'h000, 1, 0, 6));
    vt.push_back(v(1, 0, 0, 0, 0, 12'h000, 3, 12'h000, 1, 0, 6));
    vt.push_back(v(1, 0, 0, 0, 0, 12'h000, 4, 12'h000, 1, 0, 6));
    vt.push_back(v(1, 0, 1, 0, 0, 12'h000, 0, 12'h000, 0, 1, 7)); // halt_req in WB
    vt.push_back(v(1, 1, 0, 0, 0, 12'h000, 0, 12'h000, 1, 0, 7));
    vt.push_back(v(1, 0, 0, 0, 0, 12'h000, 1, 12'h000, 1, 0, 7));
    vt.push_back(v(1, 0, 0, 0, 1, 12'h055, 2, 12'h000, 1, 0, 7)); // en in ID ignored
    vt.push_back(v(1, 0, 0, 0, 0, 12'h000, 3, 12'h000, 1, 0, 7));
    vt.push_back(v(0, 1, 1, 1, 1, 12'h123, 0, 12'h000, 0, 0, 0)); // reset in MEM w/ stall
    vt.push_back(v(1, 0, 0, 0, 0, 12'h000, 0, 12'h000, 0, 0, 0));

    foreach (vt[i]) begin
      drive(vt[i].rst_n, vt[i].run, vt[i].halt, vt[i].stall, vt[i].en, vt[i].npc);
      check($sformatf("vec%0d", i), vt[i].ph, vt[i].pc, vt[i].ro, vt[i].ho, vt[i].ret);
    end

    // Retired counter wraps mod 2^CW; jumps load a fresh pc each instruction.
    drive(1, 1, 0, 0, 0, 12'h000);
    check("wrap_start", 0, 12'h000, 1, 0, 0);
    for (int n = 1; n <= 9; n++) begin
      logic [11:0] tgt;
      logic [CW-1:0] er;
      tgt = 12'(n * 12'h111);
      er  = CW'(n);
      drive(1, 0, 0, 0, 0, 12'h000);
      drive(1, 0, 0, 0, 0, 12'h000);
      drive(1, 0, 0, 0, 1, tgt);
      drive(1, 0, 0, 0, 0, 12'h000);
      drive(1, 0, 0, 0, 0, 12'h000);
      check($sformatf("wrap%0d", n), 0, tgt, 1, 0, er);
    end

    // Stall in WB defers both retire and a pending halt.
    drive(1, 0, 1, 0, 0, 12'h000);
    drive(1, 0, 0, 0, 0, 12'h000);
    drive(1, 0, 0, 0, 0, 12'h000);
    drive(1, 0, 0, 0, 0, 12'h000);
    drive(1, 0, 0, 1, 0, 12'h000);
    check("wb_stall", 4, 12'h999, 1, 0, 1);
    drive(1, 0, 0, 0, 0, 12'h000);
    check("wb_release_halt", 0, 12'h999, 0, 1, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
